// File: rtl/prng_sched.sv
// prng_sched: round-robin scheduler sharing one prng among NREQ requesters.
// Optional prefetch buffering: define PRNG_SCHED_PREFETCH_EN.
module prng_sched #(
    parameter int NREQ      = 4,
    parameter int OUTLENGTH = 1600,
    parameter int PRNG_LAT  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic [OUTLENGTH-1:0] rnd_out,
    output logic                 prng_ren,
    input  logic [OUTLENGTH-1:0] prng_dout,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DELIVER
`ifdef PRNG_SCHED_PREFETCH_EN
        ,
        REFILL,
        RWAIT
`endif
    } state_t;

    state_t                state, state_d;
    logic [PW-1:0]         ptr, ptr_d;
    logic [PW-1:0]         win, win_d;
    logic [PW-1:0]         arb_win;
    logic                  arb_any;
    logic [PW:0]           idx;
    logic [3:0]            cnt, cnt_d;
    logic [NREQ-1:0]       gnt_d;
    logic                  ren_d;
    logic                  busy_d;
    logic [OUTLENGTH-1:0]  rnd_d;
`ifdef PRNG_SCHED_PREFETCH_EN
    logic [OUTLENGTH-1:0]  pbuf, pbuf_d;
    logic                  vld, vld_d;
`endif

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // Round-robin pick: first pending req starting at ptr+1, wrapping.
    always_comb begin
        arb_any = 1'b0;
        arb_win = '0;
        idx     = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, ptr} + (PW+1)'(k + 1);
            if (idx >= (PW+1)'(NREQ))
                idx = idx - (PW+1)'(NREQ);
            if (!arb_any && req[idx[PW-1:0]]) begin
                arb_any = 1'b1;
                arb_win = idx[PW-1:0];
            end
        end
    end

    // Next-state and next-output logic; all outputs are registered below.
    always_comb begin
        state_d = state;
        win_d   = win;
        ptr_d   = ptr;
        cnt_d   = cnt;
        rnd_d   = rnd_out;
        gnt_d   = '0;
        ren_d   = 1'b0;
`ifdef PRNG_SCHED_PREFETCH_EN
        pbuf_d  = pbuf;
        vld_d   = vld;
`endif
        unique case (state)
            IDLE: begin
`ifdef PRNG_SCHED_PREFETCH_EN
                if (!vld) begin
                    ren_d   = 1'b1;
                    state_d = REFILL;
                end else if (arb_any) begin
                    win_d   = arb_win;
                    rnd_d   = pbuf;
                    vld_d   = 1'b0;
                    gnt_d   = onehot(arb_win);
                    state_d = DELIVER;
                end
`else
                if (arb_any) begin
                    win_d   = arb_win;
                    ren_d   = 1'b1;
                    state_d = ISSUE;
                end
`endif
            end
            ISSUE: begin
                cnt_d   = 4'(PRNG_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    rnd_d   = prng_dout;
                    gnt_d   = onehot(win);
                    state_d = DELIVER;
                end
            end
            DELIVER: begin
                ptr_d = win;
`ifdef PRNG_SCHED_PREFETCH_EN
                ren_d   = 1'b1;
                state_d = REFILL;
`else
                state_d = IDLE;
`endif
            end
`ifdef PRNG_SCHED_PREFETCH_EN
            REFILL: begin
                cnt_d   = 4'(PRNG_LAT);
                state_d = RWAIT;
            end
            RWAIT: begin
                cnt_d = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    if (arb_any) begin
                        // A requester is already waiting: hand the word over directly.
                        win_d   = arb_win;
                        rnd_d   = prng_dout;
                        gnt_d   = onehot(arb_win);
                        state_d = DELIVER;
                    end else begin
                        pbuf_d  = prng_dout;
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= PW'(NREQ - 1);
            win      <= '0;
            cnt      <= '0;
            gnt      <= '0;
            prng_ren <= 1'b0;
            busy     <= 1'b0;
            rnd_out  <= '0;
`ifdef PRNG_SCHED_PREFETCH_EN
            pbuf     <= '0;
            vld      <= 1'b0;
`endif
        end else begin
            state    <= state_d;
            ptr      <= ptr_d;
            win      <= win_d;
            cnt      <= cnt_d;
            gnt      <= gnt_d;
            prng_ren <= ren_d;
            busy     <= busy_d;
            rnd_out  <= rnd_d;
`ifdef PRNG_SCHED_PREFETCH_EN
            pbuf     <= pbuf_d;
            vld      <= vld_d;
`endif
        end
    end

endmodule
